// File: rtl/mem_access_unit_if.sv
// Request/response bus between the core and the load/store unit, plus the
// word-wide data memory port the unit drives.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] load_data;
   logic        done;
   logic        addr_error;
   logic [7:0]  dm_address;
   logic [31:0] dm_write_data;
   logic        dm_mem_write;
   logic        dm_mem_read;
   logic [31:0] dm_read_data;

   modport slave (
      input  req_valid, mem_read, mem_write, size, sign_ext, address, write_data, dm_read_data,
      output req_ready, load_data, done, addr_error, dm_address, dm_write_data, dm_mem_write, dm_mem_read
   );

   modport master (
      output req_valid, mem_read, mem_write, size, sign_ext, address, write_data, dm_read_data,
      input  req_ready, load_data, done, addr_error, dm_address, dm_write_data, dm_mem_write, dm_mem_read
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer: maps data-segment byte addresses to word indices,
// does subword stores as read-modify-write and rejects bad accesses.
module mem_access_unit #(
   parameter int          DATA_WIDTH  = 32,
   parameter logic [31:0] DATA_BASE   = 32'h10010000,
   parameter int          DEPTH_WORDS = 256
) (
   input logic              clk,
   input logic              reset,
   mem_access_unit_if.slave bus
);

   localparam logic [31:0] SPAN_BYTES = 32'(4 * DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t                  state_q, state_d;
   logic                    err_q, err_d;
   logic                    op_read_q, op_read_d;
   logic [7:0]              index_q, index_d;
   logic [DATA_WIDTH-1:0]   load_data_q, load_data_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [1:0]              size_q, size_d;
   logic                    sign_ext_q, sign_ext_d;
   logic [1:0]              lane_q, lane_d;

   logic [31:0]             offset;
   logic                    req_err;
   logic                    accept;

   // Replace only the addressed byte/half lane of the captured word.
   function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [31:0] data,
                                              input logic [1:0] sz, input logic [1:0] lane);
      logic [31:0] res;
      res = word;
      case (sz)
         2'b00:   res[{lane, 3'b000} +: 8]      = data[7:0];
         2'b01:   res[{lane[1], 4'b0000} +: 16] = data[15:0];
         default: res                           = data;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic sext);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (sz)
         2'b00:   return sext ? 32'(b) : {24'd0, b};
         2'b01:   return sext ? 32'(h) : {16'd0, h};
         default: return word;
      endcase
   endfunction

   // Unsigned subtraction makes addresses below the base wrap to huge offsets.
   assign offset  = bus.address - DATA_BASE;
   assign req_err = (offset >= SPAN_BYTES)
                 || (bus.size == 2'b01 && bus.address[0])
                 || (bus.size == 2'b10 && bus.address[1:0] != 2'b00)
                 || (bus.size == 2'b11)
                 || (bus.mem_read && bus.mem_write);
   assign accept  = bus.req_valid && (state_q == IDLE) && (bus.mem_read || bus.mem_write);

   always_comb begin
      state_d     = state_q;
      err_d       = err_q;
      op_read_d   = op_read_q;
      index_d     = index_q;
      load_data_d = load_data_q;
      rdata_d     = rdata_q;
      wdata_d     = wdata_q;
      size_d      = size_q;
      sign_ext_d  = sign_ext_q;
      lane_d      = lane_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               err_d      = req_err;
               op_read_d  = bus.mem_read;
               index_d    = offset[9:2];
               size_d     = bus.size;
               sign_ext_d = bus.sign_ext;
               lane_d     = bus.address[1:0];
               wdata_d    = bus.write_data;
               if (req_err)
                  state_d = RESP;
               else if (bus.mem_read || bus.size != 2'b10)
                  state_d = READ;
               else
                  state_d = WRITE;
            end
         end
         READ: begin
            if (op_read_q) begin
               load_data_d = extract_lane(bus.dm_read_data, size_q, lane_q, sign_ext_q);
               state_d     = RESP;
            end else begin
               rdata_d = bus.dm_read_data;
               state_d = WRITE;
            end
         end
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control state: reset forces IDLE and kills any pending memory write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         err_q       <= 1'b0;
         op_read_q   <= 1'b0;
         index_q     <= '0;
         load_data_q <= '0;
      end else begin
         state_q     <= state_d;
         err_q       <= err_d;
         op_read_q   <= op_read_d;
         index_q     <= index_d;
         load_data_q <= load_data_d;
      end
   end

   // Request payload: only consumed in states entered after an accept.
   always_ff @(posedge clk) begin
      rdata_q    <= rdata_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      sign_ext_q <= sign_ext_d;
      lane_q     <= lane_d;
   end

   assign bus.req_ready     = (state_q == IDLE);
   assign bus.done          = (state_q == RESP);
   assign bus.addr_error    = (state_q == RESP) && err_q;
   assign bus.load_data     = load_data_q;
   assign bus.dm_mem_read   = (state_q == READ);
   assign bus.dm_mem_write  = (state_q == WRITE);
   assign bus.dm_address    = (state_q == READ || state_q == WRITE) ? index_q : 8'd0;
   assign bus.dm_write_data = (state_q != WRITE) ? 32'd0
                            : (size_q == 2'b10)  ? wdata_q
                            : merge_lane(rdata_q, wdata_q, size_q, lane_q);

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: directed cases with literal expectations, then random
// traffic compared every cycle against a transaction-level reference model.
module tb_mem_access_unit;
   localparam logic [31:0] BASE = 32'h10010000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   mem_access_unit_if bus();

   mem_access_unit #(.DATA_WIDTH(32), .DATA_BASE(BASE), .DEPTH_WORDS(256)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Environment memory seen by the DUT, and the model's own copy.
   logic [31:0] mem     [256];
   logic [31:0] ref_mem [256];

   assign bus.dm_read_data = mem[bus.dm_address];
   always @(posedge clk) if (bus.dm_mem_write === 1'b1) mem[bus.dm_address] <= bus.dm_write_data;

   typedef struct {
      bit          err;
      bit          is_load;
      int          lat;
      int          rd_cyc;
      int          wr_cyc;
      logic [7:0]  idx;
      logic [31:0] word;
      logic [31:0] ldata;
   } exp_t;

   exp_t        e;
   int          phase = 0;
   logic [31:0] model_load = '0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // What one accepted request must do, from the addressing and lane rules.
   function automatic exp_t predict(input logic rd, input logic wr, input logic [1:0] sz,
                                    input logic sx, input logic [31:0] a, input logic [31:0] wd);
      exp_t        r;
      logic [31:0] off, cur, sh, mask, lanev;
      off   = a - BASE;
      r.err = (off >= 32'd1024) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
           || (sz == 2'd3) || (rd && wr);
      r.idx = off[9:2];
      cur   = ref_mem[r.idx];
      sh    = (sz == 2'd0) ? {27'd0, a[1:0], 3'd0} : {27'd0, a[1], 4'd0};
      mask  = ((sz == 2'd0) ? 32'h000000FF : 32'h0000FFFF) << sh;
      lanev = (cur & mask) >> sh;
      r.is_load = rd;
      if (sz == 2'd2)                      r.ldata = cur;
      else if (sz == 2'd0 && sx && lanev[7])  r.ldata = lanev | 32'hFFFFFF00;
      else if (sz == 2'd1 && sx && lanev[15]) r.ldata = lanev | 32'hFFFF0000;
      else                                 r.ldata = lanev;
      r.word   = (sz == 2'd2) ? wd : ((cur & ~mask) | ((wd << sh) & mask));
      r.lat    = r.err ? 1 : (rd ? 2 : ((sz == 2'd2) ? 2 : 3));
      r.rd_cyc = (!r.err && (rd || sz != 2'd2)) ? 1 : 0;
      r.wr_cyc = (!r.err && !rd) ? r.lat - 1 : 0;
      return r;
   endfunction

   // Model: phase counts cycles since the accept edge, 0 when idle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         phase      <= 0;
         model_load <= '0;
      end else if (phase == 0) begin
         if (bus.req_valid && (bus.mem_read || bus.mem_write)) begin
            e     <= predict(bus.mem_read, bus.mem_write, bus.size, bus.sign_ext, bus.address, bus.write_data);
            phase <= 1;
         end
      end else if (phase >= e.lat) begin
         phase <= 0;
      end else begin
         phase <= phase + 1;
         if (phase + 1 == e.lat && !e.err) begin
            if (e.is_load) model_load <= e.ldata;
            else           ref_mem[e.idx] <= e.word;
         end
      end
   end

   always @(negedge clk) begin
      logic in_rd, in_wr;
      in_rd = (phase != 0) && (phase == e.rd_cyc);
      in_wr = (phase != 0) && (phase == e.wr_cyc);
      chk1("req_ready", bus.req_ready, phase == 0);
      chk1("done", bus.done, (phase != 0) && (phase == e.lat));
      chk1("addr_error", bus.addr_error, (phase != 0) && (phase == e.lat) && e.err);
      chk32("load_data", bus.load_data, model_load);
      chk1("dm_mem_read", bus.dm_mem_read, in_rd);
      chk1("dm_mem_write", bus.dm_mem_write, in_wr);
      if (in_rd || in_wr) chk32("dm_address", {24'd0, bus.dm_address}, {24'd0, e.idx});
      if (in_wr) chk32("dm_write_data", bus.dm_write_data, e.word);
   end

   task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd);
      bus.mem_read   = rd;
      bus.mem_write  = wr;
      bus.size       = sz;
      bus.sign_ext   = sx;
      bus.address    = a;
      bus.write_data = wd;
   endtask

   // One request from idle; returns cycles from accept edge to done and the error flag.
   task automatic txn(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd, output int lat, output logic err);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!bus.req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      drive(rd, wr, sz, sx, a, wd);
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.done && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      err = bus.addr_error;
   endtask

   task automatic rand_req();
      logic [1:0]  sz;
      logic [31:0] a, amask;
      int          op, r;
      op = $urandom_range(0, 7);
      r  = $urandom_range(0, 9);
      sz = (r == 0) ? 2'd3 : 2'(r % 3);
      amask = (sz == 2'd2) ? 32'hFFFFFFFC : (sz == 2'd1) ? 32'hFFFFFFFE : 32'hFFFFFFFF;
      r = $urandom_range(0, 9);
      if (r < 5)       a = (BASE + $urandom_range(0, 63)) & amask;
      else if (r < 7)  a = BASE + $urandom_range(0, 1023);
      else if (r == 7) a = BASE + 32'd1024 + $urandom_range(0, 7);
      else if (r == 8) a = BASE - $urandom_range(1, 8);
      else             a = $urandom;
      drive(op == 1 || (op >= 2 && op <= 4), op == 1 || op >= 5, sz, 1'($urandom), a, $urandom);
   endtask

   initial begin
      int   lat, dones;
      logic err;
      for (int i = 0; i < 256; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      bus.req_valid = 1'b0;
      drive(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

      #1 rst = 1'b1;
      #3;
      chk1("rst_req_ready", bus.req_ready, 1'b1);
      chk1("rst_done", bus.done, 1'b0);
      chk1("rst_addr_error", bus.addr_error, 1'b0);
      chk32("rst_load_data", bus.load_data, 32'd0);
      chk1("rst_dm_mem_write", bus.dm_mem_write, 1'b0);
      chk1("rst_dm_mem_read", bus.dm_mem_read, 1'b0);
      chk32("rst_dm_address", {24'd0, bus.dm_address}, 32'd0);
      chk32("rst_dm_write_data", bus.dm_write_data, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      txn(1'b0, 1'b1, 2'd2, 1'b0, BASE + 32'h8, 32'hDEADBEEF, lat, err);
      chk32("sw_lat", lat, 2);
      chk32("sw_mem2", mem[2], 32'hDEADBEEF);
      txn(1'b1, 1'b0, 2'd2, 1'b0, BASE + 32'h8, 32'h0, lat, err);
      chk32("lw_lat", lat, 2);
      chk32("lw_data", bus.load_data, 32'hDEADBEEF);
      txn(1'b0, 1'b1, 2'd0, 1'b0, BASE + 32'hA, 32'h00000080, lat, err);
      chk32("sb_lat", lat, 3);
      chk32("sb_mem2", mem[2], 32'hDE80BEEF);
      txn(1'b1, 1'b0, 2'd0, 1'b1, BASE + 32'hA, 32'h0, lat, err);
      chk32("lb_data", bus.load_data, 32'hFFFFFF80);
      txn(1'b1, 1'b0, 2'd0, 1'b0, BASE + 32'hA, 32'h0, lat, err);
      chk32("lbu_data", bus.load_data, 32'h00000080);
      txn(1'b0, 1'b1, 2'd1, 1'b0, BASE + 32'hE, 32'hAAAA1234, lat, err);
      chk32("sh_lat", lat, 3);
      chk32("sh_mem3", mem[3], 32'h12340000);
      txn(1'b1, 1'b0, 2'd1, 1'b1, BASE + 32'hC, 32'h0, lat, err);
      chk32("lh_lo_data", bus.load_data, 32'h00000000);
      txn(1'b1, 1'b0, 2'd1, 1'b1, BASE + 32'hE, 32'h0, lat, err);
      chk32("lh_hi_data", bus.load_data, 32'h00001234);

      txn(1'b1, 1'b0, 2'd2, 1'b0, BASE + 32'h6, 32'h0, lat, err);
      chk32("err_lw_mis_lat", lat, 1);
      chk1("err_lw_mis_flag", err, 1'b1);
      txn(1'b0, 1'b1, 2'd1, 1'b0, BASE + 32'h1, 32'hFFFF, lat, err);
      chk32("err_sh_mis_lat", lat, 1);
      chk1("err_sh_mis_flag", err, 1'b1);
      txn(1'b1, 1'b0, 2'd2, 1'b0, BASE + 32'h400, 32'h0, lat, err);
      chk32("err_lw_hi_lat", lat, 1);
      chk1("err_lw_hi_flag", err, 1'b1);
      txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000FFFC, 32'h0, lat, err);
      chk32("err_lw_lo_lat", lat, 1);
      chk1("err_lw_lo_flag", err, 1'b1);
      chk32("err_keeps_load", bus.load_data, 32'h00001234);
      chk32("err_mem3_intact", mem[3], 32'h12340000);

      // Reset during the READ cycle of a byte store.
      @(negedge clk);
      drive(1'b0, 1'b1, 2'd0, 1'b0, BASE + 32'h8, 32'h55);
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk1("rstrd_in_read", bus.dm_mem_read, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("rstrd_read_drop", bus.dm_mem_read, 1'b0);
      chk1("rstrd_write_low", bus.dm_mem_write, 1'b0);
      chk1("rstrd_ready", bus.req_ready, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk1("rstrd_no_done", bus.done, 1'b0);
      end
      chk32("rstrd_mem2", mem[2], 32'hDE80BEEF);

      // Reset during the WRITE cycle of a word store.
      drive(1'b0, 1'b1, 2'd2, 1'b0, BASE + 32'h8, 32'h11111111);
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk1("rstwr_in_write", bus.dm_mem_write, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("rstwr_write_drop", bus.dm_mem_write, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk32("rstwr_mem2", mem[2], 32'hDE80BEEF);

      // req_valid held high with no operation: never accepted.
      bus.req_valid = 1'b1;
      drive(1'b0, 1'b0, 2'd2, 1'b0, BASE, 32'h0);
      repeat (5) begin
         @(negedge clk);
         chk1("noop_ready", bus.req_ready, 1'b1);
      end

      // Back-to-back word loads: one accept every 3 cycles.
      drive(1'b1, 1'b0, 2'd2, 1'b0, BASE + 32'h8, 32'h0);
      dones = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (bus.done) dones++;
         drive(1'b1, 1'b0, 2'd2, 1'b0, BASE + {22'd0, 8'($urandom), 2'b00}, 32'h0);
      end
      chk32("b2b_done_count", dones, 10);
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clk);

      // Random traffic with occasional asynchronous resets.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         bus.req_valid = ($urandom_range(0, 9) < 7);
         rand_req();
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      bus.req_valid = 1'b0;
      repeat (6) @(negedge clk);

      for (int i = 0; i < 256; i++) chk32("final_mem", mem[i], ref_mem[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
